// File: rtl/vp_pkg.sv
// Shared definitions for the vector processor register-read path.
// Register widths, bank sizes, operand type encodings and the
// {type,idx} scoreboard key used to address the pending bits.
package vp_pkg;

  localparam int unsigned EW   = 21;   // scalar register width
  localparam int unsigned VW   = 192;  // vector register width
  localparam int unsigned NREG = 16;   // registers per bank
  localparam int unsigned IDXW = 4;    // register index width

  localparam logic TYPE_SCALAR = 1'b0;
  localparam logic TYPE_VEC    = 1'b1;

  typedef logic [IDXW-1:0] reg_idx_t;
  typedef logic [IDXW:0]   sb_key_t;   // {type, idx}

  function automatic sb_key_t sb_key(input logic typ, input reg_idx_t idx);
    return {typ, idx};
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundle of all non-clock/reset signals of the operand fetch stage:
// decode handshake, register file read data, writeback bus, flush and
// the execute-side output slot.
//   master: upstream/environment side (drives decode, RF, WB, flush, ex_ready)
//   slave : the operand fetch stage itself
interface operand_fetch_stage_if;
  import vp_pkg::*;

  // decode side
  logic          id_valid;
  logic          id_ready;
  reg_idx_t      id_src1;
  reg_idx_t      id_src2;
  logic          id_use1;
  logic          id_use2;
  logic          id_type1;
  logic          id_type2;
  reg_idx_t      id_dest;
  logic          id_destType;
  logic [1:0]    id_wb;
  // register file read data
  logic [EW-1:0] rf_e1;
  logic [EW-1:0] rf_e2;
  logic [VW-1:0] rf_v1;
  logic [VW-1:0] rf_v2;
  // writeback bus
  logic          wb_en;
  reg_idx_t      wb_dest;
  logic          wb_destType;
  logic [EW-1:0] wbEscalar;
  logic [VW-1:0] wbVector;
  // control
  logic          flush;
  // execute side
  logic          ex_valid;
  logic          ex_ready;
  logic [EW-1:0] ex_r1e;
  logic [EW-1:0] ex_r2e;
  logic [VW-1:0] ex_r1v;
  logic [VW-1:0] ex_r2v;
  reg_idx_t      ex_dest;
  logic          ex_destType;
  logic [1:0]    ex_wb;

  modport master (
    output id_valid, id_src1, id_src2, id_use1, id_use2, id_type1, id_type2,
           id_dest, id_destType, id_wb, rf_e1, rf_e2, rf_v1, rf_v2,
           wb_en, wb_dest, wb_destType, wbEscalar, wbVector, flush, ex_ready,
    input  id_ready, ex_valid, ex_r1e, ex_r2e, ex_r1v, ex_r2v, ex_dest,
           ex_destType, ex_wb
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use1, id_use2, id_type1, id_type2,
           id_dest, id_destType, id_wb, rf_e1, rf_e2, rf_v1, rf_v2,
           wb_en, wb_dest, wb_destType, wbEscalar, wbVector, flush, ex_ready,
    output id_ready, ex_valid, ex_r1e, ex_r2e, ex_r1v, ex_r2v, ex_dest,
           ex_destType, ex_wb
  );

endinterface

// File: rtl/of_scoreboard.sv
// Pending-writeback scoreboard for the operand fetch stage.
// One pending bit per {type,idx}; set when an instruction that writes a
// register is accepted, cleared by writeback or by flushing the held slot.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   set_en/set_key      mark a destination pending
//   clr_en/clr_key      writeback clear (also exempts same-cycle hazards)
//   fclr_en/fclr_key    clear for a flushed in-flight instruction
//   use1/src1_key, use2/src2_key  source operands to check
//   dest_wr/dest_key    destination to check for WAW
//   haz1, haz2, haz_waw hazard flags
module of_scoreboard
  import vp_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    set_en,
  input  sb_key_t set_key,
  input  logic    clr_en,
  input  sb_key_t clr_key,
  input  logic    fclr_en,
  input  sb_key_t fclr_key,
  input  logic    use1,
  input  sb_key_t src1_key,
  input  logic    use2,
  input  sb_key_t src2_key,
  input  logic    dest_wr,
  input  sb_key_t dest_key,
  output logic    haz1,
  output logic    haz2,
  output logic    haz_waw
);

  logic [2*NREG-1:0] pending_q, pending_d;

  // A register whose writeback lands this cycle is no longer a hazard:
  // its data is bypassed from the WB bus.
  function automatic logic busy(input logic [2*NREG-1:0] pend, input sb_key_t key,
                                input logic wclr, input sb_key_t wkey);
    return pend[key] && !(wclr && (wkey == key));
  endfunction

  assign haz1    = use1    && busy(pending_q, src1_key, clr_en, clr_key);
  assign haz2    = use2    && busy(pending_q, src2_key, clr_en, clr_key);
  assign haz_waw = dest_wr && busy(pending_q, dest_key, clr_en, clr_key);

  // Clears first, set last: a new writer wins over a same-cycle clear.
  always_comb begin
    pending_d = pending_q;
    if (fclr_en) pending_d[fclr_key] = 1'b0;
    if (clr_en)  pending_d[clr_key]  = 1'b0;
    if (set_en)  pending_d[set_key]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-read stage of the vector processor. Accepts decoded instructions,
// reads scalar and vector source operands (with same-cycle WB bypass), stalls
// on scoreboard hazards and registers everything into one valid/ready slot
// feeding execute.
// Ports:
//   clk  clock
//   rst  synchronous active-low reset
//   bus  operand_fetch_stage_if.slave: decode handshake, RF read data,
//        WB bus, flush and the execute output slot
module operand_fetch_stage
  import vp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  operand_fetch_stage_if.slave  bus
);

  logic haz1, haz2, haz_waw;
  logic slot_free, id_ready, accept, id_writes, fclr_en;

  logic [EW-1:0] op1e, op2e;
  logic [VW-1:0] op1v, op2v;

  logic          ex_valid_q;
  logic [EW-1:0] ex_r1e_q, ex_r2e_q;
  logic [VW-1:0] ex_r1v_q, ex_r2v_q;
  reg_idx_t      ex_dest_q;
  logic          ex_destType_q;
  logic [1:0]    ex_wb_q;

  assign id_writes = (bus.id_wb != 2'b00);
  assign slot_free = !ex_valid_q || bus.ex_ready;
  // Gated by rst so nothing looks accepted while reset is asserted.
  assign id_ready  = rst && slot_free && !haz1 && !haz2 && !haz_waw && !bus.flush;
  assign accept    = bus.id_valid && id_ready;
  // Flushing a valid writer frees its destination; nothing else will clear it.
  assign fclr_en   = bus.flush && ex_valid_q && (ex_wb_q != 2'b00);

  of_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && id_writes),
    .set_key  (sb_key(bus.id_destType, bus.id_dest)),
    .clr_en   (bus.wb_en),
    .clr_key  (sb_key(bus.wb_destType, bus.wb_dest)),
    .fclr_en  (fclr_en),
    .fclr_key (sb_key(ex_destType_q, ex_dest_q)),
    .use1     (bus.id_use1),
    .src1_key (sb_key(bus.id_type1, bus.id_src1)),
    .use2     (bus.id_use2),
    .src2_key (sb_key(bus.id_type2, bus.id_src2)),
    .dest_wr  (id_writes),
    .dest_key (sb_key(bus.id_destType, bus.id_dest)),
    .haz1     (haz1),
    .haz2     (haz2),
    .haz_waw  (haz_waw)
  );

  // Per-bank bypass: each bank only takes WB data when the WB type matches it.
  always_comb begin
    op1e = bus.rf_e1;
    op2e = bus.rf_e2;
    op1v = bus.rf_v1;
    op2v = bus.rf_v2;
    if (bus.wb_en) begin
      if (bus.wb_destType == TYPE_SCALAR) begin
        if (bus.wb_dest == bus.id_src1) op1e = bus.wbEscalar;
        if (bus.wb_dest == bus.id_src2) op2e = bus.wbEscalar;
      end
      if (bus.wb_destType == TYPE_VEC) begin
        if (bus.wb_dest == bus.id_src1) op1v = bus.wbVector;
        if (bus.wb_dest == bus.id_src2) op2v = bus.wbVector;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_q    <= 1'b0;
      ex_r1e_q      <= '0;
      ex_r2e_q      <= '0;
      ex_r1v_q      <= '0;
      ex_r2v_q      <= '0;
      ex_dest_q     <= '0;
      ex_destType_q <= 1'b0;
      ex_wb_q       <= 2'b00;
    end else if (accept) begin
      ex_valid_q    <= 1'b1;
      ex_r1e_q      <= op1e;
      ex_r2e_q      <= op2e;
      ex_r1v_q      <= op1v;
      ex_r2v_q      <= op2v;
      ex_dest_q     <= bus.id_dest;
      ex_destType_q <= bus.id_destType;
      ex_wb_q       <= bus.id_wb;
    end else if (bus.ex_ready || bus.flush) begin
      // Data stays put; only the valid bit drops.
      ex_valid_q    <= 1'b0;
    end
  end

  assign bus.id_ready    = id_ready;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_r1e      = ex_r1e_q;
  assign bus.ex_r2e      = ex_r2e_q;
  assign bus.ex_r1v      = ex_r1v_q;
  assign bus.ex_r2v      = ex_r2v_q;
  assign bus.ex_dest     = ex_dest_q;
  assign bus.ex_destType = ex_destType_q;
  assign bus.ex_wb       = ex_wb_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
  import vp_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  operand_fetch_stage_if bus ();

  operand_fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    bus.id_valid    = 1'b0;
    bus.id_src1     = '0;
    bus.id_src2     = '0;
    bus.id_use1     = 1'b0;
    bus.id_use2     = 1'b0;
    bus.id_type1    = 1'b0;
    bus.id_type2    = 1'b0;
    bus.id_dest     = '0;
    bus.id_destType = 1'b0;
    bus.id_wb       = 2'b00;
    bus.rf_e1       = '0;
    bus.rf_e2       = '0;
    bus.rf_v1       = '0;
    bus.rf_v2       = '0;
    bus.wb_en       = 1'b0;
    bus.wb_dest     = '0;
    bus.wb_destType = 1'b0;
    bus.wbEscalar   = '0;
    bus.wbVector    = '0;
    bus.flush       = 1'b0;
    bus.ex_ready    = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [432:0] all_data;
    idle();
    rst = 1'b0;
    bus.id_valid = 1'b1;
    bus.id_wb    = 2'b01;
    #1;
    total++;
    if (bus.id_ready !== 1'b0) begin
      bad++; $display("FAIL reset_id_ready0 got=%b want=0", bus.id_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      all_data = {bus.ex_r1e, bus.ex_r2e, bus.ex_r1v, bus.ex_r2v, bus.ex_dest,
                  bus.ex_destType, bus.ex_wb};
      total++;
      if (bus.ex_valid !== 1'b0) begin
        bad++; $display("FAIL reset_ex_valid cyc=%0d got=%b want=0", i, bus.ex_valid);
      end
      total++;
      if (all_data !== '0) begin
        bad++; $display("FAIL reset_ex_data cyc=%0d got=%h want=0", i, all_data);
      end
      total++;
      if (bus.id_ready !== 1'b0) begin
        bad++; $display("FAIL reset_id_ready cyc=%0d got=%b want=0", i, bus.id_ready);
      end
    end
    rst = 1'b1;
    idle();
    #1;
    total++;
    if (bus.id_ready !== 1'b1) begin
      bad++; $display("FAIL release_id_ready got=%b want=1", bus.id_ready);
    end
    tick();
  endtask

  task automatic test_scalar_read();
    idle();
    bus.id_valid = 1'b1;
    bus.id_src1  = 4'd1;
    bus.id_src2  = 4'd2;
    bus.id_use1  = 1'b1;
    bus.id_use2  = 1'b1;
    bus.id_dest  = 4'd9;
    bus.rf_e1    = 21'h1ABCD;
    bus.rf_e2    = 21'h00042;
    #1;
    total++;
    if (bus.id_ready !== 1'b1) begin
      bad++; $display("FAIL scalar_id_ready got=%b want=1", bus.id_ready);
    end
    tick();
    idle();
    total++;
    if (bus.ex_valid !== 1'b1) begin
      bad++; $display("FAIL scalar_ex_valid got=%b want=1", bus.ex_valid);
    end
    total++;
    if (bus.ex_r1e !== 21'h1ABCD || bus.ex_r2e !== 21'h00042) begin
      bad++; $display("FAIL scalar_operands got=%h/%h want=1abcd/00042", bus.ex_r1e, bus.ex_r2e);
    end
    total++;
    if (bus.ex_dest !== 4'd9 || bus.ex_wb !== 2'b00) begin
      bad++; $display("FAIL scalar_dest got=%0d/%b want=9/00", bus.ex_dest, bus.ex_wb);
    end
    tick();
    total++;
    if (bus.ex_valid !== 1'b0) begin
      bad++; $display("FAIL scalar_drain got=%b want=0", bus.ex_valid);
    end
  endtask

  task automatic test_raw_bypass();
    logic [VW-1:0] beef;
    logic [VW-1:0] junk;
    logic [VW-1:0] other;
    beef  = {12{16'hBEEF}};
    junk  = {6{32'h12345678}};
    other = {6{32'h0BADF00D}};
    idle();
    bus.id_valid    = 1'b1;
    bus.id_dest     = 4'd3;
    bus.id_destType = TYPE_VEC;
    bus.id_wb       = 2'b01;
    tick();
    idle();
    bus.id_valid = 1'b1;
    bus.id_src1  = 4'd3;
    bus.id_type1 = TYPE_VEC;
    bus.id_use1  = 1'b1;
    bus.id_src2  = 4'd5;
    bus.id_type2 = TYPE_VEC;
    bus.id_use2  = 1'b1;
    bus.id_dest  = 4'd4;
    bus.rf_v1    = junk;
    bus.rf_v2    = other;
    bus.rf_e1    = 21'h00123;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (bus.id_ready !== 1'b0) begin
        bad++; $display("FAIL raw_stall cyc=%0d got=%b want=0", i, bus.id_ready);
      end
      tick();
    end
    total++;
    if (bus.ex_valid !== 1'b0) begin
      bad++; $display("FAIL raw_bubble got=%b want=0", bus.ex_valid);
    end
    bus.wb_en       = 1'b1;
    bus.wb_dest     = 4'd3;
    bus.wb_destType = TYPE_VEC;
    bus.wbVector    = beef;
    bus.wbEscalar   = 21'h1F0F0;
    #1;
    total++;
    if (bus.id_ready !== 1'b1) begin
      bad++; $display("FAIL raw_wb_release got=%b want=1", bus.id_ready);
    end
    tick();
    idle();
    total++;
    if (bus.ex_valid !== 1'b1 || bus.ex_r1v !== beef) begin
      bad++; $display("FAIL raw_bypass_v got=%b/%h want=1/%h", bus.ex_valid, bus.ex_r1v, beef);
    end
    total++;
    if (bus.ex_r1e !== 21'h00123 || bus.ex_r2v !== other) begin
      bad++; $display("FAIL raw_no_cross_bank got=%h/%h want=00123/%h", bus.ex_r1e, bus.ex_r2v,
                      other);
    end
    tick();
  endtask

  task automatic test_backpressure();
    idle();
    bus.ex_ready = 1'b0;
    bus.id_valid = 1'b1;
    bus.id_src1  = 4'd1;
    bus.id_use1  = 1'b1;
    bus.id_dest  = 4'd2;
    bus.rf_e1    = 21'h0AAAA;
    tick();
    bus.rf_e1 = 21'h05555;
    bus.id_dest = 4'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.id_ready !== 1'b0) begin
        bad++; $display("FAIL bp_id_ready cyc=%0d got=%b want=0", i, bus.id_ready);
      end
      tick();
      total++;
      if (bus.ex_valid !== 1'b1 || bus.ex_r1e !== 21'h0AAAA || bus.ex_dest !== 4'd2) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d want=1/0aaaa/2", i, bus.ex_valid,
                        bus.ex_r1e, bus.ex_dest);
      end
    end
    bus.ex_ready = 1'b1;
    #1;
    total++;
    if (bus.id_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got=%b want=1", bus.id_ready);
    end
    tick();
    idle();
    total++;
    if (bus.ex_valid !== 1'b1 || bus.ex_r1e !== 21'h05555 || bus.ex_dest !== 4'd6) begin
      bad++; $display("FAIL bp_next got=%b/%h/%0d want=1/05555/6", bus.ex_valid, bus.ex_r1e,
                      bus.ex_dest);
    end
    tick();
  endtask

  task automatic test_collision();
    idle();
    bus.id_valid = 1'b1;
    bus.id_dest  = 4'd5;
    bus.id_wb    = 2'b01;
    tick();
    bus.wb_en       = 1'b1;
    bus.wb_dest     = 4'd5;
    bus.wb_destType = TYPE_SCALAR;
    #1;
    total++;
    if (bus.id_ready !== 1'b1) begin
      bad++; $display("FAIL coll_waw_exempt got=%b want=1", bus.id_ready);
    end
    tick();
    idle();
    bus.id_valid = 1'b1;
    bus.id_src1  = 4'd5;
    bus.id_use1  = 1'b1;
    bus.id_dest  = 4'd8;
    bus.rf_e1    = 21'h00001;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (bus.id_ready !== 1'b0) begin
        bad++; $display("FAIL coll_set_wins cyc=%0d got=%b want=0", i, bus.id_ready);
      end
      tick();
    end
    bus.wb_en       = 1'b1;
    bus.wb_dest     = 4'd5;
    bus.wb_destType = TYPE_SCALAR;
    bus.wbEscalar   = 21'h15555;
    #1;
    total++;
    if (bus.id_ready !== 1'b1) begin
      bad++; $display("FAIL coll_clear got=%b want=1", bus.id_ready);
    end
    tick();
    idle();
    total++;
    if (bus.ex_r1e !== 21'h15555) begin
      bad++; $display("FAIL coll_bypass_e got=%h want=15555", bus.ex_r1e);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [VW-1:0] cafe;
    cafe = {6{32'hCAFEF00D}};
    idle();
    bus.ex_ready    = 1'b0;
    bus.id_valid    = 1'b1;
    bus.id_dest     = 4'd7;
    bus.id_destType = TYPE_VEC;
    bus.id_wb       = 2'b10;
    tick();
    total++;
    if (bus.ex_valid !== 1'b1 || bus.ex_wb !== 2'b10 || bus.ex_dest !== 4'd7 ||
        bus.ex_destType !== 1'b1) begin
      bad++; $display("FAIL flush_held got=%b/%b/%0d/%b want=1/10/7/1", bus.ex_valid, bus.ex_wb,
                      bus.ex_dest, bus.ex_destType);
    end
    idle();
    bus.ex_ready = 1'b0;
    bus.id_valid = 1'b1;
    bus.id_src1  = 4'd7;
    bus.id_type1 = TYPE_VEC;
    bus.id_use1  = 1'b1;
    bus.rf_v1    = cafe;
    bus.flush    = 1'b1;
    #1;
    total++;
    if (bus.id_ready !== 1'b0) begin
      bad++; $display("FAIL flush_blocks got=%b want=0", bus.id_ready);
    end
    tick();
    bus.flush = 1'b0;
    total++;
    if (bus.ex_valid !== 1'b0) begin
      bad++; $display("FAIL flush_kill got=%b want=0", bus.ex_valid);
    end
    #1;
    total++;
    if (bus.id_ready !== 1'b1) begin
      bad++; $display("FAIL flush_pending_clr got=%b want=1", bus.id_ready);
    end
    tick();
    idle();
    total++;
    if (bus.ex_valid !== 1'b1 || bus.ex_r1v !== cafe) begin
      bad++; $display("FAIL flush_after got=%b/%h want=1/%h", bus.ex_valid, bus.ex_r1v, cafe);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_scalar_read();
    test_raw_bypass();
    test_backpressure();
    test_collision();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Register-read stage of the vector processor; the reading end of the scalar/vector register file that WB_Stage writes.
- Accepts decoded instructions from decode and reads source operands from the 16x21-bit scalar and 16x192-bit vector banks.
- Tracks in-flight writebacks in a scoreboard and bypasses same-cycle WB data.
- Registers operands into a valid/ready pipeline slot feeding execute.

Parameters:
- EW, 21, scalar register width
- VW, 192, vector register width
- NREG, 16, registers per bank (index width 4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- id_valid  in  1  decoded instruction present
- id_ready  out  1  stage accepts instruction this cycle
- id_src1, id_src2  in  4  source indices
- id_use1, id_use2  in  1  source operand is used
- id_type1, id_type2  in  1  source type: 0 scalar, 1 vector
- id_dest  in  4  destination index
- id_destType  in  1  destination type: 0 scalar, 1 vector
- id_wb  in  2  writeback control; nonzero means the instruction writes a register
- rf_e1, rf_e2  in  EW  scalar file read data at id_src1/id_src2 (combinational read)
- rf_v1, rf_v2  in  VW  vector file read data at id_src1/id_src2
- wb_en  in  1  WB writes this cycle
- wb_dest  in  4  WB destination
- wb_destType  in  1  WB destination type
- wbEscalar  in  EW  WB scalar data
- wbVector  in  VW  WB vector data
- flush  in  1  kill the held output instruction
- ex_valid  out  1  output slot valid
- ex_ready  in  1  execute consumes the slot
- ex_r1e, ex_r2e  out  EW  scalar operands
- ex_r1v, ex_r2v  out  VW  vector operands
- ex_dest  out  4  destination index
- ex_destType  out  1  destination type
- ex_wb  out  2  writeback control

Behaviour:
- Reset (rst=0 at a clk edge): all scoreboard bits clear; ex_valid=0; all ex_* data outputs 0. Reset overrides every other input.
- Scoreboard: 32 pending bits, index {type,idx}.
- Hazard for source k: used and pending[{type_k,src_k}] and not (wb_en and wb_dest==src_k and wb_destType==type_k).
- WAW hazard: id_wb!=0 and pending[{id_destType,id_dest}], with the same WB-clear exemption as source hazards.
- Operand bypass: for each operand and each bank, if wb_en and the WB index/type match, select wbEscalar/wbVector; otherwise select rf_*. Both banks are always loaded for both operands.
- slot_free = !ex_valid or ex_ready.
- id_ready = slot_free and no hazard and !flush.
- accept = id_valid and id_ready.
- On accept: load all ex_* fields; ex_valid<=1. Latency: one cycle from accept to ex_valid.
- If !accept and ex_ready: ex_valid<=0. Otherwise hold all ex_* stable; data must not change while ex_valid and !ex_ready.
- Scoreboard set: on accept with id_wb!=0, set pending[{id_destType,id_dest}].
- Scoreboard clear: on wb_en, clear pending[{wb_destType,wb_dest}].
- Set and clear on the same bit in the same cycle: set wins.
- Flush: ex_valid<=0 and no accept that cycle. If the held slot was valid with ex_wb!=0, clear its pending bit. WB clears in the same cycle still apply.
- A source equal to the destination of the same instruction is not a hazard on itself; only pre-existing pending bits count.
- wb_en for a non-pending register clears nothing harmful; no error is flagged.

Decomposition:
- Shared package vp_pkg:
  - EW, VW, NREG
  - TYPE_SCALAR=0, TYPE_VEC=1
  - typedef for register index (4 bits)
  - typedef for the 5-bit scoreboard key {type,idx}
- One sub-module, of_scoreboard: holds the 32 pending bits and the set/clear/flush-clear logic, and returns the hazard flags.
- Bypass muxes and the output register stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with id_valid=1 -> ex_valid=0, all ex_* 0, id_ready=0 during reset; first cycle after release id_ready=1.
- Scalar operand read: rf_e1=21'h1ABCD, rf_e2=21'h00042, no pending, ex_ready=1 -> next cycle ex_valid=1, ex_r1e=21'h1ABCD, ex_r2e=21'h00042.
- RAW stall then bypass: issue I1 writing V3; I2 uses vector src1=3 -> id_ready=0 until wb_en with wb_dest=3, wb_destType=1, wbVector={12{16'hBEEF}}. In that same cycle id_ready=1 and the next cycle ex_r1v={12{16'hBEEF}}.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> id_ready=0 and ex_* unchanged; ex_ready=1 -> slot drains and the next instruction loads.
- Set/clear collision: WB clears scalar R5 in the same cycle that a new instruction writing R5 is accepted -> pending[{0,5}] remains 1 and a dependent reader stalls.
- Flush: held slot with ex_wb=2'b10, dest V7, flush=1 -> ex_valid=0 next cycle and pending[{1,7}]=0; an instruction using V7 is accepted without stall.
